// File: rtl/sec_pkg.sv
// Shared types and helpers for the iterative masked Kogge-Stone adder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, width helpers for the shared operands and the
// randomness bus, and a share-local zero-filling left shift.
package sec_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest single share the shift helper handles.
  localparam int KMAX = 256;

  function automatic int mask_width(input int k, input int n);
    return k * n;
  endfunction

  function automatic int rnd_width(input int k, input int n);
    return k * n * (n - 1);
  endfunction

  function automatic int log_k(input int k);
    return $clog2(k);
  endfunction

  // Left shift of one k-bit share by d, zero-filled; bits shifted past
  // bit k-1 are dropped so nothing leaks into a neighbouring share.
  function automatic logic [KMAX-1:0] shl_share(input logic [KMAX-1:0] v,
                                                input int k, input int d);
    logic [KMAX-1:0] r;
    r = v << d;
    for (int i = 0; i < KMAX; i++) begin
      if (i >= k) r[i] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sec_and_dom.sv
// Domain-oriented masked AND of two Boolean-shared operands (q = a & b).
// Latency: 1 cycle; q is a share-local XOR of terms registered when en is high.
// Backpressure: none; en low holds the registered terms, clr zeroes them.
//
// Ports: clk, rst (async, active high), en, clr, a/b (shared operands,
// share i at [i*K_WIDTH +: K_WIDTH]), rnd (one K_WIDTH slice per share pair),
// q (shared product).
module sec_and_dom #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3,
  localparam int MW = K_WIDTH * N_SHARES,
  localparam int RW = K_WIDTH * N_SHARES * (N_SHARES - 1) / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [MW-1:0] a,
  input  logic [MW-1:0] b,
  input  logic [RW-1:0] rnd,
  output logic [MW-1:0] q
);

  // Index of the random slice shared by domains i and j (i != j).
  function automatic int pair_idx(input int i, input int j);
    int lo, hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * N_SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // t_r[i][j]: inner-domain product (i == j) or remasked cross-domain
  // product (i != j). The register stage separates the remasking from the
  // compression so glitches cannot combine unmasked cross terms.
  logic [K_WIDTH-1:0] t_r [N_SHARES][N_SHARES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SHARES; i++)
        for (int j = 0; j < N_SHARES; j++)
          t_r[i][j] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_SHARES; i++)
        for (int j = 0; j < N_SHARES; j++)
          t_r[i][j] <= '0;
    end else if (en) begin
      for (int i = 0; i < N_SHARES; i++)
        for (int j = 0; j < N_SHARES; j++)
          if (i == j)
            t_r[i][j] <= a[i*K_WIDTH +: K_WIDTH] & b[i*K_WIDTH +: K_WIDTH];
          else
            t_r[i][j] <= (a[i*K_WIDTH +: K_WIDTH] & b[j*K_WIDTH +: K_WIDTH])
                         ^ rnd[pair_idx(i, j)*K_WIDTH +: K_WIDTH];
    end
  end

  // Compression stays inside domain i.
  always_comb begin
    q = '0;
    for (int i = 0; i < N_SHARES; i++)
      for (int j = 0; j < N_SHARES; j++)
        q[i*K_WIDTH +: K_WIDTH] = q[i*K_WIDTH +: K_WIDTH] ^ t_r[i][j];
  end

endmodule

// File: rtl/sec_ksa_iter.sv
// Iterative masked Kogge-Stone adder: z = x + y mod 2^K_WIDTH, Boolean-shared.
// Latency: out_vld rises LOG_K+2 cycles after accept; one op per LOG_K+3 cycles.
// Backpressure: in_rdy only in IDLE; z/out_vld held in DONE until out_rdy.
//
// Ports: clk, rst (async, active high); in_vld/in_rdy with x, y (shared
// operands); rnd/rnd_req (fresh randomness, consumed while rnd_req is high);
// out_vld/out_rdy with z (shared sum); busy (FSM not idle).
// Build option SEC_KSA_SCRUB_EN: clear all data registers on DONE->IDLE.
module sec_ksa_iter
  import sec_pkg::*;
#(
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 3,
  parameter int MASKWIDTH = mask_width(K_WIDTH, N_SHARES),
  parameter int LOG_K     = log_k(K_WIDTH),
  parameter int RND_W     = rnd_width(K_WIDTH, N_SHARES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [MASKWIDTH-1:0] x,
  input  logic [MASKWIDTH-1:0] y,
  input  logic [RND_W-1:0]     rnd,
  output logic                 rnd_req,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [MASKWIDTH-1:0] z,
  output logic                 busy
);

`ifdef SEC_KSA_SCRUB_EN
  localparam bit SCRUB_EN = 1'b1;
`else
  localparam bit SCRUB_EN = 1'b0;
`endif

  localparam int JW   = (LOG_K > 1) ? $clog2(LOG_K) : 1;
  localparam int RW_H = RND_W / 2;

  function automatic logic [MASKWIDTH-1:0] shl_shares(input logic [MASKWIDTH-1:0] v,
                                                      input int d);
    logic [MASKWIDTH-1:0] r;
    logic [KMAX-1:0]      t;
    r = '0;
    for (int s = 0; s < N_SHARES; s++) begin
      t = shl_share(KMAX'(v[s*K_WIDTH +: K_WIDTH]), K_WIDTH, d);
      r[s*K_WIDTH +: K_WIDTH] = t[K_WIDTH-1:0];
    end
    return r;
  endfunction

  state_t               state, state_nxt;
  logic [JW-1:0]        j_r;
  logic [MASKWIDTH-1:0] xr, yr, p0_r, p_r, g_r;
  logic [MASKWIDTH-1:0] a_q, b_q, g_cur, p_cur;
  logic [MASKWIDTH-1:0] a_in0, a_in1, b_in1;
  logic                 a_en, b_en, scrub, last_round;
  int                   shift_d;

  assign last_round = (j_r == JW'(LOG_K - 1));
  assign scrub      = SCRUB_EN && (state == DONE) && out_rdy;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_vld) state_nxt = INIT;
      INIT:    state_nxt = ROUND;
      ROUND:   if (last_round) state_nxt = DONE;
      DONE:    if (out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_rdy  = (state == IDLE);
    busy    = (state != IDLE);
    out_vld = (state == DONE);
    rnd_req = (state == INIT) || (state == ROUND);
    a_en    = (state == INIT) || (state == ROUND);
    b_en    = (state == ROUND);
  end

  // Gadget outputs lag by one cycle, so the live generate vector is the
  // previous one XOR the freshly registered term, and the live propagate
  // vector is p_r only in round 0 and gadget B's output afterwards.
  // All XORs below pair share i with share i only.
  always_comb begin
    shift_d = 1 << j_r;
    g_cur   = g_r ^ a_q;
    p_cur   = (j_r == '0) ? p_r : b_q;
    if (state == INIT) begin
      a_in0 = xr;
      a_in1 = yr;
    end else begin
      a_in0 = p_cur;
      a_in1 = shl_shares(g_cur, shift_d);
    end
    b_in1 = shl_shares(p_cur, shift_d);
  end

  sec_and_dom #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES)) u_and_a (
    .clk (clk), .rst (rst), .en (a_en), .clr (scrub),
    .a (a_in0), .b (a_in1), .rnd (rnd[0 +: RW_H]), .q (a_q)
  );

  sec_and_dom #(.K_WIDTH(K_WIDTH), .N_SHARES(N_SHARES)) u_and_b (
    .clk (clk), .rst (rst), .en (b_en), .clr (scrub),
    .a (p_cur), .b (b_in1), .rnd (rnd[RW_H +: RW_H]), .q (b_q)
  );

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr <= '0; yr <= '0; p0_r <= '0; p_r <= '0; g_r <= '0; j_r <= '0;
    end else begin
      case (state)
        IDLE: if (in_vld) begin
          xr   <= x;
          yr   <= y;
          p0_r <= x ^ y;
          p_r  <= x ^ y;
          j_r  <= '0;
        end
        INIT: begin
          g_r <= '0;
          j_r <= '0;
        end
        ROUND: begin
          g_r <= g_cur;
          j_r <= j_r + JW'(1);
        end
        DONE: if (scrub) begin
          xr <= '0; yr <= '0; p0_r <= '0; p_r <= '0; g_r <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sum bit i = p0 bit i XOR carry into bit i; the final generate vector
  // is g_r ^ a_q, and the carry is that vector shifted up by one.
  assign z = p0_r ^ shl_shares(g_r ^ a_q, 1);

endmodule

// File: tb/tb_sec_ksa_iter.sv
// Directed bench for sec_ksa_iter (K_WIDTH=32, N_SHARES=3).
// Latency: checks first out_vld at cycle LOG_K+2 after accept.
// Backpressure: exercises out_rdy hold, busy-time in_vld, async reset.
module tb_sec_ksa_iter;

  localparam int K    = 32;
  localparam int MW   = 96;
  localparam int RW   = 192;
  localparam int LOGK = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [MW-1:0] x, y;
  logic [RW-1:0] rnd;
  logic          rnd_req;
  logic          out_vld;
  logic          out_rdy;
  logic [MW-1:0] z;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sec_ksa_iter dut (
    .clk (clk), .rst (rst), .in_vld (in_vld), .in_rdy (in_rdy),
    .x (x), .y (y), .rnd (rnd), .rnd_req (rnd_req),
    .out_vld (out_vld), .out_rdy (out_rdy), .z (z), .busy (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [MW-1:0] share(input logic [31:0] v);
    logic [31:0] s1, s2;
    s1 = $urandom;
    s2 = $urandom;
    return {s2, s1, v ^ s1 ^ s2};
  endfunction

  function automatic logic [31:0] recomb(input logic [MW-1:0] v);
    return v[31:0] ^ v[63:32] ^ v[95:64];
  endfunction

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Fresh randomness every cycle, changed away from the active edge.
  initial begin
    rnd = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < RW / 32; i++) rnd[i*32 +: 32] = $urandom;
    end
  end

  // One operation: accept, count cycles to out_vld, optionally inject a
  // busy-time in_vld, hold out_rdy low for 'hold' DONE cycles, handshake.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input int hold, input int inject,
                       output int lat, output int rq,
                       output logic [31:0] zr, output int rdy_bad);
    logic [31:0] e;
    e = a + b;
    lat = 0; rq = 0; rdy_bad = 0;
    x = share(a);
    y = share(b);
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 40) begin
      if (rnd_req) rq++;
      if (in_rdy || !busy) rdy_bad++;
      if (lat == inject) begin
        x = share(a ^ 32'h5A5A_0F0F);
        y = share(~b);
        in_vld = 1'b1;
      end
      @(posedge clk); #1;
      in_vld = 1'b0;
      lat++;
    end
    if (rnd_req) rq++;
    if (in_rdy || !busy) rdy_bad++;
    zr = recomb(z);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_vld", out_vld, 1);
      check("hold_z", recomb(z), e);
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check("post_hs_out_vld", out_vld, 0);
    check("post_hs_in_rdy", in_rdy, 1);
  endtask

  initial begin
    int lat, rq, bad;
    logic [31:0] zr, ra, rb, re;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[1] = '{32'h1234_5678, 32'h0FED_CBA9, 32'h2222_2221};
    vecs[2] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0008};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[7] = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF};
    vecs[8] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEF0};

    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", in_rdy, 1);
    check("rst_out_vld", out_vld, 0);
    check("rst_rnd_req", rnd_req, 0);
    check("rst_busy", busy, 0);
    check("rst_z", z, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table: latency, in_rdy/busy during op, randomness use, sum.
    for (int v = 0; v < 9; v++) begin
      do_op(vecs[v].a, vecs[v].b, 0, 0, lat, rq, zr, bad);
      check("vec_latency", lat, LOGK + 2);
      check("vec_busy_rdy", bad, 0);
      check("vec_rnd_req_cycles", rq, LOGK + 1);
      check("vec_sum", zr, vecs[v].sum);
    end

    // out_rdy held low for 5 DONE cycles.
    do_op(32'h1234_5678, 32'h0FED_CBA9, 5, 0, lat, rq, zr, bad);
    check("hold_sum", zr, 32'h2222_2221);

    // in_vld pulsed at cycle 3 with other operands must be ignored.
    do_op(32'h0BAD_F00D, 32'h1111_1111, 0, 3, lat, rq, zr, bad);
    check("inject_sum", zr, 32'h1CBF_011E);
    check("inject_rnd_req_cycles", rq, LOGK + 1);
    check("inject_latency", lat, LOGK + 2);

    // Random operands against the reference sum.
    for (int r = 0; r < 100; r++) begin
      ra = $urandom;
      rb = $urandom;
      re = ra + rb;
      do_op(ra, rb, 0, 0, lat, rq, zr, bad);
      check("rand_sum", zr, re);
    end

    // Asynchronous reset in cycle 4 of an operation.
    x = share(32'hFFFF_0000);
    y = share(32'h0001_FFFF);
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_out_vld", out_vld, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_z", z, 0);
    check("async_rst_in_rdy", in_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(32'h0000_0003, 32'h0000_0005, 0, 0, lat, rq, zr, bad);
    check("post_rst_sum", zr, 32'h0000_0008);
    check("post_rst_latency", lat, LOGK + 2);

    // z after the handshake, in IDLE.
    @(posedge clk); #1;
`ifdef SEC_KSA_SCRUB_EN
    check("scrub_z_zero", z, 0);
`else
    check("idle_z_retained", recomb(z), 32'h0000_0008);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
